msp_exec_unit: RTL and testbench
================================

Name: msp_exec_unit

Overview:
- Parametrised multicycle execution unit for the next-generation multicycle processor core.
- Replaces the fixed 8-bit ALU/shifter pair with one WIDTH-generic unit. Adds iterative barrel-free shifts, rotate, and shift-add multiply.
- Controller issues one operation via start/busy/done and receives result plus CZNV flags.
- RUN gating freezes all progress, as for the rest of the core.

Parameters:
- WIDTH, 8, datapath width in bits; power of two, 8..32.
- MUL_EN, 1, 1 enables MUL; 0 makes opcode 10 illegal.

Ports:
- clk input 1 system clock, rising-edge.
- RESET_N input 1 synchronous active-low reset.
- RUN input 1 global run enable; low freezes state, counters, outputs.
- start input 1 issue request; sampled only in IDLE with RUN=1.
- op input 4 opcode.
- a input WIDTH operand A.
- b input WIDTH operand B; shift ops use b[log2(WIDTH)-1:0] as shamt.
- set_flags input 1 captured with start; 1 = update flags at completion.
- busy output 1 high whenever state is not IDLE.
- done output 1 one-cycle completion pulse.
- err output 1 pulses with done for an illegal opcode.
- result output WIDTH registered result, held until next done.
- C, Z, N, V output 1 each; registered flags.

Behaviour:
- Reset (RESET_N=0 at an edge): state IDLE; busy, done, err = 0; result = 0; C, Z, N, V = 0; counters 0.
- Reset mid-operation aborts the operation. No done is produced.
- States:
  - IDLE: if start&RUN, capture op, a, b, set_flags; go to EXEC. Otherwise start is ignored, including when RUN=0.
  - EXEC: runs k cycles, then goes to DONE.
  - DONE: one cycle; done=1; next state IDLE.
- start in EXEC or DONE is ignored. No queueing.
- k values:
  - 1 for ADD, SUB, AND, ORR, XOR, MOV, CMP, illegal.
  - max(shamt,1) for shifts; shifts move 1 bit per cycle.
  - WIDTH for MUL; 1 shift-add step per cycle.
- Latency: done is high in the cycle after edge E(k+1), where E0 is the edge that samples start. busy is high from E0 to E(k+2).
- RUN=0 in EXEC or DONE holds everything, including done. Completion is delayed by exactly the number of RUN-low cycles.
- Ops and results (all arithmetic mod 2^WIDTH):
  - 0 ADD: a+b.
  - 1 SUB: a−b.
  - 2 AND, 3 ORR, 4 XOR: bitwise.
  - 5 MOV: b.
  - 6 LSL, 7 LSR: logical shifts.
  - 8 ASR: sign-filling shift.
  - 9 ROR: rotate right.
  - 10 MUL: low WIDTH bits of unsigned a*b.
  - 11 CMP: computes a−b for flags; result = a.
  - 12..15: illegal; result = 0, err=1 with done, flags unchanged regardless of set_flags.
- Flags are written only at DONE and only when captured set_flags=1 and op is legal.
  - N = result MSB; Z = (result==0). For CMP, N and Z come from a−b, not from result.
  - ADD: C = carry-out, V = signed overflow.
  - SUB/CMP: C = no-borrow (a>=b unsigned), V = signed overflow.
  - Logic ops and MOV: C and V unchanged.
  - Shifts: C = last bit shifted out, V unchanged. shamt=0 gives result = a, C unchanged, k=1.
  - MUL: C = 1 if the upper WIDTH product bits are nonzero; V unchanged.
- result and flags change only at the DONE transition. They are stable at all other times.

Test Plan:
- WIDTH=8, ADD a=0x7F b=0x01 set_flags=1 → done after E2; result 0x80; N=1 V=1 C=0 Z=0; busy low after E3.
- SUB a=0x05 b=0x05 set_flags=1, then CMP a=0x03 b=0x04 →
  - SUB: result 0x00, Z=1 C=1.
  - CMP: result 0x03, N=1 C=0 Z=0.
- ASR a=0x90 b=3 → result 0xF2, C=0, done after E4. ROR a=0x81 b=1 → result 0xC0, C=1. LSL b=0 → result = a, C unchanged.
- MUL a=0x10 b=0x11 set_flags=1 → result 0x10, C=1, done after E9. Repeat with RUN=0 for 3 cycles mid-EXEC → done after E12, outputs frozen during the stall.
- op=0xE with set_flags=1 → err=1 and done=1 together; result 0x00; flags unchanged. start asserted while busy → ignored, no second done.
- RESET_N=0 during MUL EXEC → next edge: busy=0, result=0, flags 0, no done.
- WIDTH=16 build: ADD 0xFFFF+0x0001 → result 0x0000, Z=1 C=1. MUL_EN=0: op 10 → err.

Source files
------------

// File: rtl/msp_exec_unit_if.sv
// Issue/result bus between the core controller and msp_exec_unit.
// The controller drives the request side and the execution unit returns
// busy/done/err, the result and the CZNV flags.
interface msp_exec_unit_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [3:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             set_flags;
   logic             busy;
   logic             done;
   logic             err;
   logic [WIDTH-1:0] result;
   logic             C;
   logic             Z;
   logic             N;
   logic             V;

   modport master (
      output start, op, a, b, set_flags,
      input  busy, done, err, result, C, Z, N, V
   );

   modport slave (
      input  start, op, a, b, set_flags,
      output busy, done, err, result, C, Z, N, V
   );
endinterface

// File: rtl/msp_exec_unit.sv
// Multicycle WIDTH-generic execution unit: single-cycle ALU ops, iterative
// one-bit-per-cycle shifts/rotate and a shift-add multiplier. One operation
// is issued through start/busy/done; result and CZNV are registered and only
// change on the cycle that raises done. RUN low freezes every register.
module msp_exec_unit #(
   parameter int WIDTH  = 8,
   parameter bit MUL_EN = 1'b1
) (
   input logic            clk,
   input logic            RESET_N,
   input logic            RUN,
   msp_exec_unit_if.slave bus
);
   localparam int SW  = $clog2(WIDTH);
   localparam int CW  = SW + 1;
   localparam int MSB = WIDTH - 1;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_ORR = 4'd3;
   localparam logic [3:0] OP_XOR = 4'd4;
   localparam logic [3:0] OP_MOV = 4'd5;
   localparam logic [3:0] OP_LSL = 4'd6;
   localparam logic [3:0] OP_LSR = 4'd7;
   localparam logic [3:0] OP_ASR = 4'd8;
   localparam logic [3:0] OP_ROR = 4'd9;
   localparam logic [3:0] OP_MUL = 4'd10;
   localparam logic [3:0] OP_CMP = 4'd11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_r;
   logic [3:0]       op_r;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;      // operand B; low product half during MUL
   logic [WIDTH-1:0] acc_r;    // shift working value; high product half during MUL
   logic             sf_r;
   logic             do_shift_r;
   logic             carry_r;  // last bit shifted out
   logic [CW-1:0]    cnt_r;    // remaining iteration steps

   logic [SW-1:0]    shamt_s;
   logic [CW-1:0]    k_s;
   logic [WIDTH-1:0] step_acc_s;
   logic [WIDTH-1:0] step_b_s;
   logic             step_c_s;
   logic [WIDTH:0]   mul_sum_s;
   logic [WIDTH:0]   sum_s;
   logic [WIDTH:0]   diff_s;
   logic [WIDTH-1:0] res_s;
   logic [WIDTH-1:0] nz_src_s;
   logic             c_s;
   logic             v_s;
   logic             legal_s;

   // Iteration count for the request on the bus: one step per shift bit, WIDTH for MUL.
   always_comb begin
      shamt_s = bus.b[SW-1:0];
      case (bus.op)
         OP_LSL, OP_LSR, OP_ASR, OP_ROR: begin
            if (shamt_s == {SW{1'b0}}) begin
               k_s = CW'(1);
            end else begin
               k_s = CW'(shamt_s);
            end
         end
         OP_MUL: begin
            if (MUL_EN) begin
               k_s = CW'(WIDTH);
            end else begin
               k_s = CW'(1);
            end
         end
         default: k_s = CW'(1);
      endcase
   end

   // One iteration step: shift/rotate one bit, or one shift-add multiply step.
   always_comb begin
      step_acc_s = acc_r;
      step_b_s   = b_r;
      step_c_s   = carry_r;
      mul_sum_s  = {1'b0, acc_r};
      case (op_r)
         OP_LSL: begin
            if (do_shift_r) begin
               step_acc_s = {acc_r[MSB-1:0], 1'b0};
               step_c_s   = acc_r[MSB];
            end else begin
               step_acc_s = acc_r;
            end
         end
         OP_LSR: begin
            if (do_shift_r) begin
               step_acc_s = {1'b0, acc_r[MSB:1]};
               step_c_s   = acc_r[0];
            end else begin
               step_acc_s = acc_r;
            end
         end
         OP_ASR: begin
            if (do_shift_r) begin
               step_acc_s = {acc_r[MSB], acc_r[MSB:1]};
               step_c_s   = acc_r[0];
            end else begin
               step_acc_s = acc_r;
            end
         end
         OP_ROR: begin
            if (do_shift_r) begin
               step_acc_s = {acc_r[0], acc_r[MSB:1]};
               step_c_s   = acc_r[0];
            end else begin
               step_acc_s = acc_r;
            end
         end
         OP_MUL: begin
            // Multiplier bits leave b_r from the bottom while product bits enter at the top.
            if (b_r[0]) begin
               mul_sum_s = {1'b0, acc_r} + {1'b0, a_r};
            end else begin
               mul_sum_s = {1'b0, acc_r};
            end
            step_acc_s = mul_sum_s[WIDTH:1];
            step_b_s   = {mul_sum_s[0], b_r[MSB:1]};
         end
         default: step_acc_s = acc_r;
      endcase
   end

   // Final result and flag values presented when the operation completes.
   always_comb begin
      sum_s    = {1'b0, a_r} + {1'b0, b_r};
      diff_s   = {1'b0, a_r} - {1'b0, b_r};
      legal_s  = 1'b1;
      res_s    = {WIDTH{1'b0}};
      nz_src_s = {WIDTH{1'b0}};
      c_s      = bus.C;
      v_s      = bus.V;
      case (op_r)
         OP_ADD: begin
            res_s    = sum_s[MSB:0];
            nz_src_s = sum_s[MSB:0];
            c_s      = sum_s[WIDTH];
            v_s      = (a_r[MSB] == b_r[MSB]) && (sum_s[MSB] != a_r[MSB]);
         end
         OP_SUB: begin
            res_s    = diff_s[MSB:0];
            nz_src_s = diff_s[MSB:0];
            c_s      = ~diff_s[WIDTH];
            v_s      = (a_r[MSB] != b_r[MSB]) && (diff_s[MSB] != a_r[MSB]);
         end
         OP_CMP: begin
            res_s    = a_r;
            nz_src_s = diff_s[MSB:0];
            c_s      = ~diff_s[WIDTH];
            v_s      = (a_r[MSB] != b_r[MSB]) && (diff_s[MSB] != a_r[MSB]);
         end
         OP_AND: begin
            res_s    = a_r & b_r;
            nz_src_s = a_r & b_r;
         end
         OP_ORR: begin
            res_s    = a_r | b_r;
            nz_src_s = a_r | b_r;
         end
         OP_XOR: begin
            res_s    = a_r ^ b_r;
            nz_src_s = a_r ^ b_r;
         end
         OP_MOV: begin
            res_s    = b_r;
            nz_src_s = b_r;
         end
         OP_LSL, OP_LSR, OP_ASR, OP_ROR: begin
            res_s    = acc_r;
            nz_src_s = acc_r;
            // A zero shift amount moves no bit out, so carry keeps its old value.
            if (do_shift_r) begin
               c_s = carry_r;
            end else begin
               c_s = bus.C;
            end
         end
         OP_MUL: begin
            if (MUL_EN) begin
               res_s    = b_r;
               nz_src_s = b_r;
               c_s      = |acc_r;
            end else begin
               legal_s  = 1'b0;
            end
         end
         default: legal_s = 1'b0;
      endcase
   end

   // Control FSM with registered busy/done/err, result and flags; RUN low holds everything.
   always_ff @(posedge clk) begin
      if (!RESET_N) begin
         state_r    <= IDLE;
         op_r       <= 4'd0;
         a_r        <= {WIDTH{1'b0}};
         b_r        <= {WIDTH{1'b0}};
         acc_r      <= {WIDTH{1'b0}};
         sf_r       <= 1'b0;
         do_shift_r <= 1'b0;
         carry_r    <= 1'b0;
         cnt_r      <= {CW{1'b0}};
         bus.busy   <= 1'b0;
         bus.done   <= 1'b0;
         bus.err    <= 1'b0;
         bus.result <= {WIDTH{1'b0}};
         bus.C      <= 1'b0;
         bus.Z      <= 1'b0;
         bus.N      <= 1'b0;
         bus.V      <= 1'b0;
      end else if (RUN) begin
         case (state_r)
            IDLE: begin
               bus.done <= 1'b0;
               bus.err  <= 1'b0;
               if (bus.start) begin
                  op_r       <= bus.op;
                  a_r        <= bus.a;
                  b_r        <= bus.b;
                  sf_r       <= bus.set_flags;
                  do_shift_r <= (shamt_s != {SW{1'b0}});
                  carry_r    <= 1'b0;
                  cnt_r      <= k_s;
                  if (bus.op == OP_MUL) begin
                     acc_r <= {WIDTH{1'b0}};
                  end else begin
                     acc_r <= bus.a;
                  end
                  bus.busy <= 1'b1;
                  state_r  <= EXEC;
               end else begin
                  bus.busy <= 1'b0;
               end
            end
            EXEC: begin
               if (cnt_r != {CW{1'b0}}) begin
                  cnt_r   <= cnt_r - CW'(1);
                  acc_r   <= step_acc_s;
                  b_r     <= step_b_s;
                  carry_r <= step_c_s;
               end else begin
                  bus.result <= res_s;
                  bus.done   <= 1'b1;
                  bus.err    <= ~legal_s;
                  if (legal_s && sf_r) begin
                     bus.N <= nz_src_s[MSB];
                     bus.Z <= (nz_src_s == {WIDTH{1'b0}});
                     bus.C <= c_s;
                     bus.V <= v_s;
                  end else begin
                     bus.N <= bus.N;
                  end
                  state_r <= DONE;
               end
            end
            DONE: begin
               bus.done <= 1'b0;
               bus.err  <= 1'b0;
               bus.busy <= 1'b0;
               state_r  <= IDLE;
            end
            default: begin
               bus.busy <= 1'b0;
               state_r  <= IDLE;
            end
         endcase
      end else begin
         state_r <= state_r;
      end
   end
endmodule

// File: tb/tb_msp_exec_unit.sv
// Directed bench for msp_exec_unit: an 8-bit MUL-enabled instance and a
// 16-bit instance without MUL. Inputs change and outputs are sampled on the
// falling edge; edge counts are relative to E0, the edge that samples start.
module tb_msp_exec_unit;
   logic clk;
   logic rst_n;
   logic run;
   int   n_cmp = 0;
   int   n_bad = 0;

   msp_exec_unit_if #(.WIDTH(8))  b8 ();
   msp_exec_unit_if #(.WIDTH(16)) b16 ();

   msp_exec_unit #(.WIDTH(8), .MUL_EN(1'b1)) dut8 (
      .clk(clk), .RESET_N(rst_n), .RUN(run), .bus(b8)
   );
   msp_exec_unit #(.WIDTH(16), .MUL_EN(1'b0)) dut16 (
      .clk(clk), .RESET_N(rst_n), .RUN(run), .bus(b16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Issue one 8-bit op and return the edge index at which done appeared (0 = never).
   task automatic issue8(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                         input logic sf, output int edge_n);
      @(negedge clk);
      b8.op = o; b8.a = x; b8.b = y; b8.set_flags = sf; b8.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      b8.start = 1'b0;
      edge_n = 0;
      for (int i = 1; i <= 60; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (b8.done === 1'b1) begin
            edge_n = i;
            break;
         end
      end
   endtask

   // Issue one 16-bit op and return the edge index at which done appeared (0 = never).
   task automatic issue16(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                          input logic sf, output int edge_n);
      @(negedge clk);
      b16.op = o; b16.a = x; b16.b = y; b16.set_flags = sf; b16.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      b16.start = 1'b0;
      edge_n = 0;
      for (int i = 1; i <= 60; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (b16.done === 1'b1) begin
            edge_n = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++; if ({b8.busy, b8.done, b8.err} !== 3'b000) begin n_bad++; $display("FAIL reset_ctl8: got %b want 000", {b8.busy, b8.done, b8.err}); end
      n_cmp++; if (b8.result !== 8'h00) begin n_bad++; $display("FAIL reset_res8: got %h want 00", b8.result); end
      n_cmp++; if ({b8.N, b8.Z, b8.C, b8.V} !== 4'b0000) begin n_bad++; $display("FAIL reset_flags8: got %b want 0000", {b8.N, b8.Z, b8.C, b8.V}); end
      n_cmp++; if ({b16.busy, b16.done, b16.err, b16.N, b16.Z, b16.C, b16.V} !== 7'd0 || b16.result !== 16'h0000) begin n_bad++; $display("FAIL reset_16: got ctl/flags %b result %h want 0", {b16.busy, b16.done, b16.err, b16.N, b16.Z, b16.C, b16.V}, b16.result); end
      rst_n = 1'b1;
   endtask

   task automatic test_add();
      int e;
      issue8(4'd0, 8'h7F, 8'h01, 1'b1, e);
      n_cmp++; if (e !== 2) begin n_bad++; $display("FAIL add_latency: got edge %0d want 2", e); end
      n_cmp++; if (b8.result !== 8'h80) begin n_bad++; $display("FAIL add_res: got %h want 80", b8.result); end
      n_cmp++; if ({b8.N, b8.Z, b8.C, b8.V} !== 4'b1001) begin n_bad++; $display("FAIL add_flags: got NZCV %b want 1001", {b8.N, b8.Z, b8.C, b8.V}); end
      n_cmp++; if ({b8.busy, b8.err} !== 2'b10) begin n_bad++; $display("FAIL add_busy_in_done: got busy/err %b want 10", {b8.busy, b8.err}); end
      @(posedge clk);
      @(negedge clk);
      n_cmp++; if ({b8.busy, b8.done} !== 2'b00) begin n_bad++; $display("FAIL add_after_e3: got busy/done %b want 00", {b8.busy, b8.done}); end
   endtask

   task automatic test_sub_cmp();
      int e;
      issue8(4'd1, 8'h05, 8'h05, 1'b1, e);
      n_cmp++; if (b8.result !== 8'h00 || e !== 2) begin n_bad++; $display("FAIL sub_res: got %h at edge %0d want 00 at 2", b8.result, e); end
      n_cmp++; if ({b8.N, b8.Z, b8.C, b8.V} !== 4'b0110) begin n_bad++; $display("FAIL sub_flags: got NZCV %b want 0110", {b8.N, b8.Z, b8.C, b8.V}); end
      issue8(4'd11, 8'h03, 8'h04, 1'b1, e);
      n_cmp++; if (b8.result !== 8'h03 || e !== 2) begin n_bad++; $display("FAIL cmp_res: got %h at edge %0d want 03 at 2", b8.result, e); end
      n_cmp++; if ({b8.N, b8.Z, b8.C, b8.V} !== 4'b1000) begin n_bad++; $display("FAIL cmp_flags: got NZCV %b want 1000", {b8.N, b8.Z, b8.C, b8.V}); end
   endtask

   task automatic test_shift();
      int e;
      issue8(4'd8, 8'h90, 8'h03, 1'b1, e);
      n_cmp++; if (e !== 4) begin n_bad++; $display("FAIL asr_latency: got edge %0d want 4", e); end
      n_cmp++; if (b8.result !== 8'hF2 || {b8.N, b8.Z, b8.C, b8.V} !== 4'b1000) begin n_bad++; $display("FAIL asr_res: got %h NZCV %b want F2 1000", b8.result, {b8.N, b8.Z, b8.C, b8.V}); end
      issue8(4'd9, 8'h81, 8'h01, 1'b1, e);
      n_cmp++; if (b8.result !== 8'hC0 || {b8.N, b8.Z, b8.C, b8.V} !== 4'b1010 || e !== 2) begin n_bad++; $display("FAIL ror_res: got %h NZCV %b edge %0d want C0 1010 2", b8.result, {b8.N, b8.Z, b8.C, b8.V}, e); end
      issue8(4'd6, 8'h5A, 8'h00, 1'b1, e);
      n_cmp++; if (b8.result !== 8'h5A || {b8.N, b8.Z, b8.C, b8.V} !== 4'b0010 || e !== 2) begin n_bad++; $display("FAIL lsl0_res: got %h NZCV %b edge %0d want 5A 0010 2", b8.result, {b8.N, b8.Z, b8.C, b8.V}, e); end
      issue8(4'd7, 8'h04, 8'h02, 1'b1, e);
      n_cmp++; if (b8.result !== 8'h01 || {b8.N, b8.Z, b8.C, b8.V} !== 4'b0000 || e !== 3) begin n_bad++; $display("FAIL lsr_res: got %h NZCV %b edge %0d want 01 0000 3", b8.result, {b8.N, b8.Z, b8.C, b8.V}, e); end
   endtask

   task automatic test_mul();
      int e;
      issue8(4'd10, 8'h10, 8'h11, 1'b1, e);
      n_cmp++; if (e !== 9) begin n_bad++; $display("FAIL mul_latency: got edge %0d want 9", e); end
      n_cmp++; if (b8.result !== 8'h10 || {b8.N, b8.Z, b8.C, b8.V} !== 4'b0010) begin n_bad++; $display("FAIL mul_res: got %h NZCV %b want 10 0010", b8.result, {b8.N, b8.Z, b8.C, b8.V}); end
      issue8(4'd2, 8'hF0, 8'h0F, 1'b1, e);
      n_cmp++; if (b8.result !== 8'h00 || {b8.N, b8.Z, b8.C, b8.V} !== 4'b0110) begin n_bad++; $display("FAIL and_res: got %h NZCV %b want 00 0110", b8.result, {b8.N, b8.Z, b8.C, b8.V}); end
   endtask

   task automatic test_run_stall();
      int e;
      @(negedge clk);
      b8.op = 4'd10; b8.a = 8'h10; b8.b = 8'h11; b8.set_flags = 1'b1; b8.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      b8.start = 1'b0;
      repeat (3) begin @(posedge clk); @(negedge clk); end
      run = 1'b0;
      repeat (3) begin @(posedge clk); @(negedge clk); end
      n_cmp++; if ({b8.busy, b8.done} !== 2'b10 || b8.result !== 8'h00 || {b8.N, b8.Z, b8.C, b8.V} !== 4'b0110) begin n_bad++; $display("FAIL stall_frozen: got busy/done %b result %h NZCV %b want 10 00 0110", {b8.busy, b8.done}, b8.result, {b8.N, b8.Z, b8.C, b8.V}); end
      run = 1'b1;
      e = 0;
      for (int i = 7; i <= 70; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (b8.done === 1'b1) begin
            e = i;
            break;
         end
      end
      n_cmp++; if (e !== 12 || b8.result !== 8'h10 || {b8.N, b8.Z, b8.C, b8.V} !== 4'b0010) begin n_bad++; $display("FAIL stall_done: got edge %0d result %h NZCV %b want 12 10 0010", e, b8.result, {b8.N, b8.Z, b8.C, b8.V}); end
      run = 1'b0;
      repeat (2) begin @(posedge clk); @(negedge clk); end
      n_cmp++; if ({b8.busy, b8.done} !== 2'b11) begin n_bad++; $display("FAIL stall_done_hold: got busy/done %b want 11", {b8.busy, b8.done}); end
      run = 1'b1;
      @(posedge clk);
      @(negedge clk);
      n_cmp++; if ({b8.busy, b8.done} !== 2'b00) begin n_bad++; $display("FAIL stall_release: got busy/done %b want 00", {b8.busy, b8.done}); end
      run = 1'b0;
      b8.op = 4'd0; b8.start = 1'b1;
      repeat (2) begin @(posedge clk); @(negedge clk); end
      n_cmp++; if (b8.busy !== 1'b0) begin n_bad++; $display("FAIL start_run_low: got busy %b want 0", b8.busy); end
      b8.start = 1'b0;
      run = 1'b1;
   endtask

   task automatic test_illegal_and_busy();
      int e;
      int dones;
      issue8(4'hE, 8'h55, 8'h66, 1'b1, e);
      n_cmp++; if ({b8.done, b8.err} !== 2'b11 || e !== 2) begin n_bad++; $display("FAIL illegal_err: got done/err %b edge %0d want 11 2", {b8.done, b8.err}, e); end
      n_cmp++; if (b8.result !== 8'h00 || {b8.N, b8.Z, b8.C, b8.V} !== 4'b0010) begin n_bad++; $display("FAIL illegal_res: got %h NZCV %b want 00 0010", b8.result, {b8.N, b8.Z, b8.C, b8.V}); end
      @(negedge clk);
      b8.op = 4'd10; b8.a = 8'h02; b8.b = 8'h03; b8.set_flags = 1'b0; b8.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      b8.start = 1'b0;
      dones = 0;
      e = 0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk);
         @(negedge clk);
         b8.start = 1'b0;
         if (b8.done === 1'b1) begin
            dones++;
            if (e == 0) e = i;
            b8.op = 4'd0; b8.set_flags = 1'b1; b8.start = 1'b1;
         end
         if (i == 2) begin
            b8.op = 4'd0; b8.a = 8'h01; b8.b = 8'h01; b8.set_flags = 1'b1; b8.start = 1'b1;
         end
      end
      n_cmp++; if (dones !== 1 || e !== 9) begin n_bad++; $display("FAIL busy_ignore: got %0d dones first at %0d want 1 at 9", dones, e); end
      n_cmp++; if (b8.result !== 8'h06 || {b8.N, b8.Z, b8.C, b8.V} !== 4'b0010 || b8.busy !== 1'b0) begin n_bad++; $display("FAIL mul_noflags: got %h NZCV %b busy %b want 06 0010 0", b8.result, {b8.N, b8.Z, b8.C, b8.V}, b8.busy); end
   endtask

   task automatic test_reset_mid();
      int dones;
      @(negedge clk);
      b8.op = 4'd10; b8.a = 8'hFF; b8.b = 8'hFF; b8.set_flags = 1'b1; b8.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      b8.start = 1'b0;
      repeat (4) begin @(posedge clk); @(negedge clk); end
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      n_cmp++; if ({b8.busy, b8.done, b8.err} !== 3'b000 || b8.result !== 8'h00 || {b8.N, b8.Z, b8.C, b8.V} !== 4'b0000) begin n_bad++; $display("FAIL reset_mid: got ctl %b result %h NZCV %b want 000 00 0000", {b8.busy, b8.done, b8.err}, b8.result, {b8.N, b8.Z, b8.C, b8.V}); end
      rst_n = 1'b1;
      dones = 0;
      repeat (12) begin
         @(posedge clk);
         @(negedge clk);
         if (b8.done === 1'b1) dones++;
      end
      n_cmp++; if (dones !== 0 || b8.busy !== 1'b0) begin n_bad++; $display("FAIL reset_mid_nodone: got %0d dones busy %b want 0 0", dones, b8.busy); end
   endtask

   task automatic test_width16();
      int e;
      issue16(4'd0, 16'hFFFF, 16'h0001, 1'b1, e);
      n_cmp++; if (b16.result !== 16'h0000 || {b16.N, b16.Z, b16.C, b16.V} !== 4'b0110 || e !== 2) begin n_bad++; $display("FAIL add16: got %h NZCV %b edge %0d want 0000 0110 2", b16.result, {b16.N, b16.Z, b16.C, b16.V}, e); end
      issue16(4'd10, 16'h0003, 16'h0004, 1'b1, e);
      n_cmp++; if ({b16.done, b16.err} !== 2'b11 || e !== 2) begin n_bad++; $display("FAIL mul_disabled: got done/err %b edge %0d want 11 2", {b16.done, b16.err}, e); end
      n_cmp++; if (b16.result !== 16'h0000 || {b16.N, b16.Z, b16.C, b16.V} !== 4'b0110) begin n_bad++; $display("FAIL mul_disabled_res: got %h NZCV %b want 0000 0110", b16.result, {b16.N, b16.Z, b16.C, b16.V}); end
   endtask

   initial begin
      rst_n = 1'b0;
      run = 1'b1;
      b8.start = 1'b0; b8.op = 4'd0; b8.a = 8'h00; b8.b = 8'h00; b8.set_flags = 1'b0;
      b16.start = 1'b0; b16.op = 4'd0; b16.a = 16'h0000; b16.b = 16'h0000; b16.set_flags = 1'b0;
      test_reset();
      test_add();
      test_sub_cmp();
      test_shift();
      test_mul();
      test_run_stall();
      test_illegal_and_busy();
      test_reset_mid();
      test_width16();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
